bf_relax_engine: RTL and testbench
==================================

Name: bf_relax_engine

Overview:
- Parametrised single-source Bellman-Ford engine; successor to the first-generation init/update sequencer.
- Walks an edge list in edge memory and keeps a distance table in working memory.
- Runs up to N-1 relaxation passes, exits early when a pass changes nothing, then runs one check pass for negative-cycle detection.
- Sits between the host start/status interface and the edge and distance SRAMs; all memory reads are synchronous with 1-cycle latency.

Parameters:
- NODE_W, 8, node index width; max nodes 2^NODE_W-1.
- DIST_W, 32, signed distance and weight width.
- EDGE_AW, 13, edge memory address width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  1-cycle pulse; ignored while busy.
- num_nodes  in  NODE_W  N; latched on start.
- num_edges  in  EDGE_AW+1  E; latched on start.
- src_node  in  NODE_W  source node; latched on start.
- em_addr  out  EDGE_AW  edge memory read address.
- em_data  in  2*NODE_W+DIST_W  edge word {u, v, w}; w is signed, u is MSBs.
- dm_raddr1  out  NODE_W  distance read address for u.
- dm_rdata1  in  DIST_W  distance read data for u.
- dm_raddr2  out  NODE_W  distance read address for v.
- dm_rdata2  in  DIST_W  distance read data for v.
- dm_waddr  out  NODE_W  distance write address.
- dm_wdata  out  DIST_W  distance write data.
- dm_we  out  1  distance write enable.
- busy  out  1  high from the cycle after start until done.
- done  out  1  1-cycle pulse at completion.
- neg_cycle  out  1  negative cycle found; held until next accepted start.
- err  out  1  src_node >= num_nodes; held until next accepted start.
- pass_cnt  out  NODE_W  number of completed relaxation passes.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- INF is the constant 0 followed by DIST_W-1 ones (max positive value).
- States and transitions:
  - IDLE -> INIT on start.
  - INIT:
    - Writes one node per cycle at addresses 0..N-1.
    - Written value is INF, except 0 at src_node.
    - Takes N cycles.
  - INIT -> EDGE_RD if N>1.
  - INIT -> CHK_RD if N==1.
  - EDGE_RD: drives em_addr = edge counter e.
  - DIST_RD: latches {u,v,w}; drives dm_raddr1=u, dm_raddr2=v.
  - RELAX:
    - Forms sum = du + w at DIST_W+1 bits, signed.
    - Saturates sum to the signed minimum on underflow.
    - If du != INF and sum < dv: write sum to v and set the changed flag.
    - Then e++; go to EDGE_RD if e < E, else PASS_END.
  - PASS_END:
    - pass_cnt++.
    - If changed==0: DONE with neg_cycle=0.
    - Else if pass_cnt == N-1: CHK_RD with e=0.
    - Else: clear changed, e=0, go to EDGE_RD.
  - CHK_RD/CHK_DR/CHK_EV: same 3-cycle walk as a relaxation pass, with no writes.
    - The first relaxable edge sets neg_cycle=1 and goes to DONE immediately.
    - If all E edges are checked with none relaxable: DONE.
  - DONE: pulses done for 1 cycle; busy drops the same cycle; -> IDLE.
- Per-edge cost is 3 cycles, non-pipelined, so there is no read-after-write hazard.
- Total latency: N + passes*(3E+1) + check (<=3E) + 1 cycles.
- Boundaries:
  - N==0: DONE the cycle after start; no writes; neg_cycle=0.
  - src_node >= N: err=1, DONE next cycle, no writes.
  - E==0: pass 1 is PASS_END only, changed=0, DONE.
  - Self-loop u==v with w<0: relaxes each pass; the check pass flags neg_cycle.
  - Reset mid-run: dm_we is 0 from the next edge; no further writes.
  - start asserted coincident with done: ignored.

Optional Feature:
- Macro: BF_PRED_EN.
- When defined, adds ports pm_waddr (out, NODE_W), pm_wdata (out, NODE_W) and pm_we (out, 1).
  - INIT writes all-ones (no predecessor) to every node.
  - Every RELAX write also writes u to pm at v, in the same cycle.
- When undefined: these ports and their logic are absent; timing is identical.

Decomposition:
- Package bf_pkg holds:
  - the state enum;
  - the INF constant function;
  - the edge-word field offsets (U_LSB, V_LSB, W_LSB).
- Sub-module bf_relax_alu:
  - purely combinational;
  - inputs du, dv, w; outputs sum and relax_ok;
  - contains the saturating add, the INF guard and the signed compare.

Test Plan:
- N=4, src=0, edges (0,1,5),(1,2,-2),(0,2,4),(2,3,1) -> dm final {0,5,3,4}; neg_cycle=0; pass_cnt=2 (early exit).
- N=3, src=0, edges (0,1,1),(1,2,-1),(2,1,-1) -> neg_cycle=1, done pulse, pass_cnt=2.
- N=3, src=5 -> err=1, done 2 cycles after start, dm_we never asserted.
- N=3, E=0, src=1 -> dm {INF,0,INF}; done after 3+1+1 cycles; pass_cnt=1.
- Underflow: w = signed min, du=-1 -> written value saturates to signed min.
- reset asserted during pass 1 RELAX -> all outputs 0 next cycle; a subsequent start runs cleanly.

Source files
------------

// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared state encoding, INF constant and edge-word layout for the Bellman-Ford engine
package bf_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_EDGE_RD,
    S_DIST_RD,
    S_RELAX,
    S_PASS_END,
    S_CHK_RD,
    S_CHK_DR,
    S_CHK_EV,
    S_DONE
  } state_e;

  // Largest positive signed value of the given width; doubles as "unreached".
  function automatic logic [63:0] inf_val(input int unsigned width);
    inf_val = (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Edge word is {u, v, w} with u in the MSBs.
  localparam int W_LSB = 0;

  function automatic int v_lsb(input int dist_w);
    v_lsb = dist_w;
  endfunction

  function automatic int u_lsb(input int node_w, input int dist_w);
    u_lsb = dist_w + node_w;
  endfunction

endpackage

// File: rtl/bf_relax_alu.sv
// rtl/bf_relax_alu.sv - combinational relax test: saturating du+w, INF guard, signed compare against dv
module bf_relax_alu
  import bf_pkg::*;
#(
  parameter int DIST_W = 32
) (
  input  logic signed [DIST_W-1:0] du,
  input  logic signed [DIST_W-1:0] dv,
  input  logic signed [DIST_W-1:0] w,
  output logic signed [DIST_W-1:0] sum,
  output logic                     relax_ok
);

  localparam logic [DIST_W-1:0] INF  = DIST_W'(inf_val(DIST_W));
  localparam logic [DIST_W-1:0] SMIN = {1'b1, {(DIST_W-1){1'b0}}};

  logic signed [DIST_W:0] w_wide;

  always_comb begin
    w_wide = {du[DIST_W-1], du} + {w[DIST_W-1], w};
    // Top two bits disagree only when the true sum left the DIST_W range.
    case (w_wide[DIST_W:DIST_W-1])
      2'b10:   sum = SMIN;
      2'b01:   sum = INF;
      default: sum = w_wide[DIST_W-1:0];
    endcase
    relax_ok = (du != INF) && (sum < dv);
  end

endmodule

// File: rtl/bf_relax_engine.sv
// rtl/bf_relax_engine.sv - single-source Bellman-Ford sequencer over edge/distance SRAMs
// Optional predecessor-table write port enabled by BF_PRED_EN.
module bf_relax_engine
  import bf_pkg::*;
#(
  parameter int NODE_W  = 8,
  parameter int DIST_W  = 32,
  parameter int EDGE_AW = 13
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NODE_W-1:0]          num_nodes,
  input  logic [EDGE_AW:0]           num_edges,
  input  logic [NODE_W-1:0]          src_node,
  output logic [EDGE_AW-1:0]         em_addr,
  input  logic [2*NODE_W+DIST_W-1:0] em_data,
  output logic [NODE_W-1:0]          dm_raddr1,
  input  logic [DIST_W-1:0]          dm_rdata1,
  output logic [NODE_W-1:0]          dm_raddr2,
  input  logic [DIST_W-1:0]          dm_rdata2,
  output logic [NODE_W-1:0]          dm_waddr,
  output logic [DIST_W-1:0]          dm_wdata,
  output logic                       dm_we,
  output logic                       busy,
  output logic                       done,
  output logic                       neg_cycle,
  output logic                       err,
  output logic [NODE_W-1:0]          pass_cnt
`ifdef BF_PRED_EN
  ,
  output logic [NODE_W-1:0]          pm_waddr,
  output logic [NODE_W-1:0]          pm_wdata,
  output logic                       pm_we
`endif
);

  localparam int                U_LSB = u_lsb(NODE_W, DIST_W);
  localparam int                V_LSB = v_lsb(DIST_W);
  localparam logic [DIST_W-1:0] INF   = DIST_W'(inf_val(DIST_W));
  localparam logic [NODE_W-1:0] N_ONE = 1;
  localparam logic [EDGE_AW:0]  E_ONE = 1;

  state_e              r_state, w_next;
  logic [NODE_W-1:0]   r_n, r_src, r_idx, r_pass, r_u, r_v;
  logic [EDGE_AW:0]    r_ne, r_e;
  logic [DIST_W-1:0]   r_w;
  logic                r_changed, r_neg, r_err;

  logic [EDGE_AW:0]    w_e_nx;
  logic                w_last;
  logic [NODE_W-1:0]   w_pass_nx, w_n_m1;
  logic [DIST_W-1:0]   w_sum;
  logic                w_relax_ok;

  assign w_e_nx    = r_e + E_ONE;
  assign w_last    = (w_e_nx >= r_ne);
  assign w_pass_nx = r_pass + N_ONE;
  assign w_n_m1    = r_n - N_ONE;

  assign neg_cycle = r_neg;
  assign err       = r_err;
  assign pass_cnt  = r_pass;

  bf_relax_alu #(.DIST_W(DIST_W)) u_alu (
    .du       (dm_rdata1),
    .dv       (dm_rdata2),
    .w        (r_w),
    .sum      (w_sum),
    .relax_ok (w_relax_ok)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    done      = (r_state == S_DONE);
    em_addr   = r_e[EDGE_AW-1:0];
    dm_raddr1 = r_u;
    dm_raddr2 = r_v;
    dm_waddr  = r_v;
    dm_wdata  = '0;
    dm_we     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = (num_nodes == '0) ? S_DONE : S_INIT;
      S_INIT: begin
        dm_waddr = r_idx;
        dm_wdata = (r_idx == r_src) ? '0 : INF;
        dm_we    = !r_err;
        if (r_err)                    w_next = S_DONE;
        else if (r_idx == w_n_m1) begin
          if (r_n == N_ONE)           w_next = (r_ne == '0) ? S_DONE : S_CHK_RD;
          else                        w_next = (r_ne == '0) ? S_PASS_END : S_EDGE_RD;
        end
      end
      S_EDGE_RD: w_next = S_DIST_RD;
      S_DIST_RD: begin
        dm_raddr1 = em_data[U_LSB +: NODE_W];
        dm_raddr2 = em_data[V_LSB +: NODE_W];
        w_next    = S_RELAX;
      end
      S_RELAX: begin
        dm_wdata = w_sum;
        dm_we    = w_relax_ok;
        w_next   = w_last ? S_PASS_END : S_EDGE_RD;
      end
      S_PASS_END: begin
        if (!r_changed)               w_next = S_DONE;
        else if (w_pass_nx == w_n_m1) w_next = S_CHK_RD;
        else                          w_next = S_EDGE_RD;
      end
      S_CHK_RD: w_next = S_CHK_DR;
      S_CHK_DR: begin
        dm_raddr1 = em_data[U_LSB +: NODE_W];
        dm_raddr2 = em_data[V_LSB +: NODE_W];
        w_next    = S_CHK_EV;
      end
      S_CHK_EV: w_next = (w_relax_ok || w_last) ? S_DONE : S_CHK_RD;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_n <= '0; r_src <= '0; r_idx <= '0; r_pass <= '0; r_u <= '0; r_v <= '0;
      r_ne <= '0; r_e <= '0; r_w <= '0;
      r_changed <= 1'b0; r_neg <= 1'b0; r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_n       <= num_nodes;
          r_ne      <= num_edges;
          r_src     <= src_node;
          r_err     <= (src_node >= num_nodes);
          r_neg     <= 1'b0;
          r_pass    <= '0;
          r_changed <= 1'b0;
          r_idx     <= '0;
          r_e       <= '0;
        end
        S_INIT: r_idx <= r_idx + N_ONE;
        S_DIST_RD, S_CHK_DR: begin
          r_u <= em_data[U_LSB +: NODE_W];
          r_v <= em_data[V_LSB +: NODE_W];
          r_w <= em_data[W_LSB +: DIST_W];
        end
        S_RELAX: begin
          if (w_relax_ok) r_changed <= 1'b1;
          r_e <= w_e_nx;
        end
        S_PASS_END: begin
          r_pass    <= w_pass_nx;
          r_changed <= 1'b0;
          r_e       <= '0;
        end
        S_CHK_EV: begin
          if (w_relax_ok) r_neg <= 1'b1;
          r_e <= w_e_nx;
        end
        default: ;
      endcase
    end
  end

`ifdef BF_PRED_EN
  // Predecessor entry follows every distance write; all-ones marks "no predecessor".
  assign pm_waddr = dm_waddr;
  assign pm_we    = dm_we;
  assign pm_wdata = (r_state == S_INIT) ? '1 : r_u;
`endif

endmodule

// File: tb/tb_bf_relax_engine.sv
// tb/tb_bf_relax_engine.sv - randomized and directed bench for bf_relax_engine against an array-based Bellman-Ford model
module tb_bf_relax_engine;
  localparam int NODE_W  = 8;
  localparam int DIST_W  = 32;
  localparam int EDGE_AW = 13;
  localparam int EW      = 2*NODE_W + DIST_W;
  localparam longint DMAX = 64'sh7fffffff;
  localparam longint DMIN = -64'sh80000000;

  logic clock = 1'b0;
  logic reset, start;
  logic [NODE_W-1:0]  num_nodes, src_node;
  logic [EDGE_AW:0]   num_edges;
  logic [EDGE_AW-1:0] em_addr;
  logic [EW-1:0]      em_data;
  logic [NODE_W-1:0]  dm_raddr1, dm_raddr2, dm_waddr;
  logic [DIST_W-1:0]  dm_rdata1, dm_rdata2, dm_wdata;
  logic dm_we, busy, done, neg_cycle, err;
  logic [NODE_W-1:0]  pass_cnt;
`ifdef BF_PRED_EN
  logic [NODE_W-1:0]  pm_waddr, pm_wdata;
  logic               pm_we;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int we_cnt   = 0;

  logic [EW-1:0]     emem [0:(1<<EDGE_AW)-1];
  logic [DIST_W-1:0] dmem [0:(1<<NODE_W)-1];
  int     eu [0:63];
  int     ev [0:63];
  longint ew [0:63];
  longint md [0:255];
  int     m_pass, m_lat;
  bit     m_neg, m_err;

  bf_relax_engine #(.NODE_W(NODE_W), .DIST_W(DIST_W), .EDGE_AW(EDGE_AW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .num_nodes(num_nodes), .num_edges(num_edges), .src_node(src_node),
    .em_addr(em_addr), .em_data(em_data),
    .dm_raddr1(dm_raddr1), .dm_rdata1(dm_rdata1),
    .dm_raddr2(dm_raddr2), .dm_rdata2(dm_rdata2),
    .dm_waddr(dm_waddr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .busy(busy), .done(done), .neg_cycle(neg_cycle), .err(err), .pass_cnt(pass_cnt)
`ifdef BF_PRED_EN
    , .pm_waddr(pm_waddr), .pm_wdata(pm_wdata), .pm_we(pm_we)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    em_data   <= emem[em_addr];
    dm_rdata1 <= dmem[dm_raddr1];
    dm_rdata2 <= dmem[dm_raddr2];
    if (dm_we) begin
      dmem[dm_waddr] <= dm_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint s);
    if (s < DMIN) return DMIN;
    if (s > DMAX) return DMAX;
    return s;
  endfunction

  function automatic bit relaxable(input int i);
    return (md[eu[i]] != DMAX) && (sat(md[eu[i]] + ew[i]) < md[ev[i]]);
  endfunction

  task automatic model(input int n, input int src, input int ne);
    bit ch, chk;
    int cyc;
    m_pass = 0; m_neg = 0; m_err = 0; ch = 0; cyc = 0;
    if (n == 0)   begin m_err = 1; m_lat = 1; return; end
    if (src >= n) begin m_err = 1; m_lat = 2; return; end
    for (int i = 0; i < n; i++) md[i] = (i == src) ? 0 : DMAX;
    for (int p = 1; p < n; p++) begin
      m_pass = p;
      ch = 0;
      for (int i = 0; i < ne; i++)
        if (relaxable(i)) begin md[ev[i]] = sat(md[eu[i]] + ew[i]); ch = 1; end
      if (!ch) break;
    end
    chk = (n == 1) || ch;
    if (chk)
      for (int i = 0; i < ne; i++) begin
        cyc += 3;
        if (relaxable(i)) begin m_neg = 1; break; end
      end
    m_lat = n + m_pass*(3*ne + 1) + cyc + 1;
  endtask

  task automatic set_edge(input int i, input int u, input int v, input longint w);
    eu[i] = u; ev[i] = v; ew[i] = w;
  endtask

  task automatic run(input string tag, input int n, input int src, input int ne, input bit coincide);
    int cyc, wb;
    for (int i = 0; i < ne; i++)
      emem[i] = {NODE_W'(eu[i]), NODE_W'(ev[i]), DIST_W'(ew[i])};
    model(n, src, ne);
    num_nodes = n[NODE_W-1:0];
    src_node  = src[NODE_W-1:0];
    num_edges = ne[EDGE_AW:0];
    wb = we_cnt;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    check({tag, ".busy"}, 64'(busy), 64'(m_lat > 1));
    while (!done && cyc < 5000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, ".lat"}, 64'(cyc), 64'(m_lat));
    check({tag, ".neg"}, 64'(neg_cycle), 64'(m_neg));
    check({tag, ".err"}, 64'(err), 64'(m_err));
    check({tag, ".pass"}, 64'(pass_cnt), 64'(m_pass));
    check({tag, ".busy_done"}, 64'(busy), 64'(0));
    if (m_err) check({tag, ".writes"}, 64'(we_cnt - wb), 64'(0));
    else
      for (int i = 0; i < n; i++)
        check($sformatf("%s.d%0d", tag, i), 64'(dmem[i]), 64'(md[i][DIST_W-1:0]));
    start = coincide;
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, ".idle"}, 64'({busy, done}), 64'(0));
  endtask

  initial begin
    int n, src, ne, wb;
    reset = 1'b1; start = 1'b0;
    num_nodes = '0; src_node = '0; num_edges = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.ctl", 64'({busy, done, neg_cycle, err, dm_we, pass_cnt}), 64'(0));
    check("rst.addr", 64'({em_addr, dm_waddr, dm_raddr1, dm_raddr2}), 64'(0));
    check("rst.wdata", 64'(dm_wdata), 64'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    set_edge(0, 0, 1, 5); set_edge(1, 1, 2, -2); set_edge(2, 0, 2, 4); set_edge(3, 2, 3, 1);
    run("t1", 4, 0, 4, 0);
    check("t1.pass_k", 64'(pass_cnt), 64'(2));
    check("t1.d3_k", 64'(dmem[3]), 64'(4));

    // Reset while the first edge of pass 1 is in its RELAX cycle.
    for (int i = 0; i < 4; i++) emem[i] = {NODE_W'(eu[i]), NODE_W'(ev[i]), DIST_W'(ew[i])};
    num_nodes = 4; src_node = 0; num_edges = 4;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid.ctl", 64'({busy, done, neg_cycle, err, dm_we, pass_cnt}), 64'(0));
    check("mid.addr", 64'({em_addr, dm_waddr, dm_raddr1, dm_raddr2}), 64'(0));
    reset = 1'b0;
    wb = we_cnt;
    repeat (5) @(posedge clock);
    #1;
    check("mid.writes", 64'(we_cnt - wb), 64'(0));
    run("t1b", 4, 0, 4, 0);

    set_edge(0, 0, 1, 1); set_edge(1, 1, 2, -1); set_edge(2, 2, 1, -1);
    run("t2", 3, 0, 3, 1);
    check("t2.neg_k", 64'(neg_cycle), 64'(1));
    run("t3", 3, 5, 3, 0);
    check("t3.err_k", 64'(err), 64'(1));
    run("t4", 3, 1, 0, 0);
    check("t4.d0_k", 64'(dmem[0]), 64'(32'h7fffffff));

    set_edge(0, 0, 1, -1); set_edge(1, 1, 2, DMIN);
    run("t5", 3, 0, 2, 0);
    check("t5.sat_k", 64'(dmem[2]), 64'(32'h80000000));

    run("t6", 0, 0, 2, 0);
    set_edge(0, 0, 0, -1);
    run("t7", 1, 0, 1, 0);
    set_edge(0, 1, 1, -2); set_edge(1, 0, 1, 3);
    run("t8", 3, 0, 2, 0);

    for (int k = 0; k < 25; k++) begin
      n   = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 8));
      src = ($urandom_range(0, 7) == 0) ? n + int'($urandom_range(0, 3))
                                        : ((n > 0) ? int'($urandom_range(0, n-1)) : 0);
      ne  = $urandom_range(0, 12);
      for (int i = 0; i < ne; i++) begin
        eu[i] = (n > 0) ? int'($urandom_range(0, n-1)) : 0;
        ev[i] = (n > 0) ? int'($urandom_range(0, n-1)) : 0;
        ew[i] = ($urandom_range(0, 15) == 0) ? DMIN : longint'($urandom_range(0, 24)) - 6;
      end
      run($sformatf("r%0d", k), n, src, ne, k[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
